conv_l1_ctrl: RTL and testbench

- Frame sequencer for the layer-1 3x3 convolution datapath.
- Holds the nine 8-bit kernel coefficients, written through a simple register port while idle.
- On start, reads one IMG_W x IMG_H frame from a synchronous frame memory in raster order and streams it to the datapath pixel input without gaps.
- Flags which datapath outputs are complete 3x3 windows, tags them with output row/col, and pulses done at end of frame.

---
 rtl/conv_l1_ctrl_if.sv | 21 ++
 rtl/conv_l1_ctrl.sv | 155 +++++++++++++++
 tb/tb_conv_l1_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_l1_ctrl_if.sv
// Frame-memory read bus between conv_l1_ctrl (master) and its synchronous frame memory (slave).
// Read data is expected exactly one cycle after mem_rd.
interface conv_l1_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_rdata
  );
endinterface

// File: rtl/conv_l1_ctrl.sv
// Layer-1 3x3 convolution frame sequencer: kernel register file, raster frame fetch, window flags.
// Optional CONV_L1_CTRL_FRAMECNT_EN adds a 16-bit completed-frame counter output (frame_cnt).
module conv_l1_ctrl #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 kwr_en,
  input  logic [3:0]           kwr_addr,
  input  logic [7:0]           kwr_data,
  conv_l1_ctrl_if.master       mem,
  output logic [7:0]           pxl_o,
  output logic [71:0]          kernel_o,
  output logic                 out_valid,
  output logic [7:0]           out_row,
  output logic [7:0]           out_col,
  output logic                 busy,
  output logic                 done
`ifdef CONV_L1_CTRL_FRAMECNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  localparam int N = IMG_W * IMG_H;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [7:0]        LAST_COL  = 8'(IMG_W - 1);
  localparam logic [7:0]        LAST_ROW  = 8'(IMG_H - 1);

  logic [1:0]        state_reg, state_next;
  logic              mem_rd_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              in_frame_reg;
  logic [7:0]        col_reg, row_reg;
  logic [7:0]        out_row_reg, out_col_reg;
  logic              done_reg;
  logic [7:0]        kern_reg [0:8];

  logic start_ok;
  logic last_issue;
  logic win_valid;

  assign start_ok   = (state_reg == ST_IDLE) && start;
  assign last_issue = (state_reg == ST_RUN) && (mem_addr_reg == LAST_ADDR);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (mem_addr_reg == LAST_ADDR) state_next = ST_DRAIN;
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      mem_rd_reg   <= 1'b0;
      mem_addr_reg <= '0;
      in_frame_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      in_frame_reg <= mem_rd_reg;
      // done is registered, so the pulse appears the cycle after the DONE state
      done_reg     <= (state_reg == ST_DONE);
      if (start_ok) begin
        mem_rd_reg   <= 1'b1;
        mem_addr_reg <= '0;
      end else if (last_issue) begin
        mem_rd_reg   <= 1'b0;
      end else if (state_reg == ST_RUN) begin
        mem_addr_reg <= mem_addr_reg + 1'b1;
      end
    end
  end

  // Position of the pixel currently on pxl_o; advances only while a pixel is in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (start_ok) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (in_frame_reg) begin
      if (col_reg == LAST_COL) begin
        col_reg <= '0;
        row_reg <= (row_reg == LAST_ROW) ? 8'd0 : row_reg + 8'd1;
      end else begin
        col_reg <= col_reg + 8'd1;
      end
    end
  end

  assign win_valid = in_frame_reg && (row_reg >= 8'd2) && (col_reg >= 8'd2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_row_reg <= '0;
      out_col_reg <= '0;
    end else if (win_valid) begin
      out_row_reg <= row_reg - 8'd2;
      out_col_reg <= col_reg - 8'd2;
    end
  end

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_kern
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          kern_reg[gi] <= '0;
        end else if ((state_reg == ST_IDLE) && kwr_en && (kwr_addr == 4'(gi))) begin
          kern_reg[gi] <= kwr_data;
        end
      end
      assign kernel_o[gi*8 +: 8] = kern_reg[gi];
    end
  endgenerate

`ifdef CONV_L1_CTRL_FRAMECNT_EN
  logic [15:0] frame_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_reg <= '0;
    end else if (state_reg == ST_DONE) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
`endif

  assign mem.mem_rd   = mem_rd_reg;
  assign mem.mem_addr = mem_addr_reg;
  assign pxl_o        = in_frame_reg ? mem.mem_rdata : 8'd0;
  assign out_valid    = win_valid;
  assign out_row      = win_valid ? (row_reg - 8'd2) : out_row_reg;
  assign out_col      = win_valid ? (col_reg - 8'd2) : out_col_reg;
  assign busy         = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign done         = done_reg;

endmodule

// File: tb/tb_conv_l1_ctrl.sv
// Directed bench for conv_l1_ctrl: frame memory model, reference 3x3 window sum, per-scenario tasks.
// Cycle t counts from the cycle in which start is sampled (t=0); outputs are sampled at the negedge.
module tb_conv_l1_ctrl;
  localparam int W  = 28;
  localparam int H  = 28;
  localparam int AW = 10;
  localparam int N  = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        kwr_en = 1'b0;
  logic [3:0]  kwr_addr = 4'd0;
  logic [7:0]  kwr_data = 8'd0;
  logic [7:0]  pxl_o, out_row, out_col;
  logic [71:0] kernel_o;
  logic        out_valid, busy, done;
`ifdef CONV_L1_CTRL_FRAMECNT_EN
  logic [15:0] frame_cnt;
`endif

  int passed = 0;
  int total  = 0;

  conv_l1_ctrl_if #(.ADDR_W(AW)) mem_bus ();

  conv_l1_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .kwr_en    (kwr_en),
    .kwr_addr  (kwr_addr),
    .kwr_data  (kwr_data),
    .mem       (mem_bus.master),
    .pxl_o     (pxl_o),
    .kernel_o  (kernel_o),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done)
`ifdef CONV_L1_CTRL_FRAMECNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous frame memory: data one cycle after mem_rd
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_bus.mem_rd) mem_bus.mem_rdata <= mem[mem_bus.mem_addr];
  end

  // Reference datapath history: hist[0] is the pixel one cycle before pxl_o
  logic [7:0] hist [0:2*W+1];
  always @(posedge clk) begin
    hist[0] <= pxl_o;
    for (int i = 1; i < 2*W+2; i++) hist[i] <= hist[i-1];
  end

  function automatic int conv_sum();
    int s = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int d = (2-i)*W + (2-j);
        int px = (d == 0) ? int'(pxl_o) : int'(hist[d-1]);
        s += int'(kernel_o[(i*3+j)*8 +: 8]) * px;
      end
    end
    return s;
  endfunction

  task automatic kwrite(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    kwr_en = 1'b1; kwr_addr = a; kwr_data = d;
    @(negedge clk);
    kwr_en = 1'b0;
  endtask

  task automatic fill_mem(input bit ones);
    for (int i = 0; i < (1<<AW); i++) mem[i] = ones ? 8'd1 : 8'(i);
  endtask

  task automatic run_frame(output bit got);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < N + 20; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({pxl_o, out_valid, out_row, out_col, busy, done} !== 26'd0) $display("FAIL reset_outputs got=%h want=0", {pxl_o, out_valid, out_row, out_col, busy, done}); else passed++;
    total++; if ({mem_bus.mem_rd, mem_bus.mem_addr} !== 11'd0) $display("FAIL reset_mem got=%h want=0", {mem_bus.mem_rd, mem_bus.mem_addr}); else passed++;
    total++; if (kernel_o !== 72'd0) $display("FAIL reset_kernel got=%h want=0", kernel_o); else passed++;
    reset = 1'b1;
    @(negedge clk);
    $display("reset: outputs and kernel checked");
  endtask

  task automatic test_kernel_load();
    kwrite(4'd0, 8'd1);
    total++; if (kernel_o !== 72'h01) $display("FAIL kernel_first_write got=%h want=01", kernel_o); else passed++;
    for (int i = 1; i < 9; i++) kwrite(4'(i), 8'(i+1));
    total++; if (kernel_o !== 72'h090807060504030201) $display("FAIL kernel_load got=%h want=090807060504030201", kernel_o); else passed++;
    kwrite(4'd9, 8'hFF);
    total++; if (kernel_o !== 72'h090807060504030201) $display("FAIL kernel_addr9 got=%h want=090807060504030201", kernel_o); else passed++;
    $display("kernel_load: kernel_o=%h", kernel_o);
  endtask

  task automatic test_nominal_frame();
    int vcount = 0;
    int last_r = -1, last_c = -1;
    fill_mem(1'b0);
    @(negedge clk); start = 1'b1;
    for (int t = 1; t <= N + 6; t++) begin
      bit exp_rd, exp_v;
      int k, r, c;
      logic [7:0] exp_px;
      @(negedge clk);
      start = 1'b0;
      k = t - 2; r = k / W; c = k % W;
      exp_rd = (t >= 1) && (t <= N);
      exp_px = (t >= 2 && t <= N+1) ? 8'(k) : 8'd0;
      exp_v  = (t >= 2 && t <= N+1) && (r >= 2) && (c >= 2);
      total++; if (mem_bus.mem_rd !== exp_rd) $display("FAIL nom_mem_rd t=%0d got=%b want=%b", t, mem_bus.mem_rd, exp_rd); else passed++;
      if (exp_rd) begin
        total++; if (mem_bus.mem_addr !== AW'(t-1)) $display("FAIL nom_mem_addr t=%0d got=%0d want=%0d", t, mem_bus.mem_addr, t-1); else passed++;
      end
      total++; if (pxl_o !== exp_px) $display("FAIL nom_pxl t=%0d got=%0d want=%0d", t, pxl_o, exp_px); else passed++;
      total++; if (busy !== (t <= N+1)) $display("FAIL nom_busy t=%0d got=%b want=%b", t, busy, t <= N+1); else passed++;
      total++; if (done !== (t == N+3)) $display("FAIL nom_done t=%0d got=%b want=%b", t, done, t == N+3); else passed++;
      total++; if (out_valid !== exp_v) $display("FAIL nom_out_valid t=%0d got=%b want=%b", t, out_valid, exp_v); else passed++;
      if (exp_v) begin
        vcount++; last_r = r - 2; last_c = c - 2;
        total++; if (out_row !== 8'(r-2) || out_col !== 8'(c-2)) $display("FAIL nom_pos t=%0d got=%0d,%0d want=%0d,%0d", t, out_row, out_col, r-2, c-2); else passed++;
      end
    end
    total++; if (vcount != (W-2)*(H-2)) $display("FAIL nom_valid_count got=%0d want=%0d", vcount, (W-2)*(H-2)); else passed++;
    total++; if (last_r != 25 || last_c != 25) $display("FAIL nom_last_pos got=%0d,%0d want=25,25", last_r, last_c); else passed++;
    total++; if (out_row !== 8'd25 || out_col !== 8'd25) $display("FAIL nom_pos_hold got=%0d,%0d want=25,25", out_row, out_col); else passed++;
    $display("nominal_frame: %0d valid windows, last %0d,%0d", vcount, last_r, last_c);
  endtask

  task automatic test_datapath();
    int vcount = 0;
    for (int i = 0; i < 9; i++) kwrite(4'(i), 8'd1);
    fill_mem(1'b1);
    @(negedge clk); start = 1'b1;
    for (int t = 1; t <= N + 6; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) begin
        vcount++;
        total++; if (conv_sum() != 9) $display("FAIL dp_sum t=%0d row=%0d col=%0d got=%0d want=9", t, out_row, out_col, conv_sum()); else passed++;
      end
    end
    total++; if (vcount != (W-2)*(H-2)) $display("FAIL dp_valid_count got=%0d want=%0d", vcount, (W-2)*(H-2)); else passed++;
    $display("datapath: %0d windows summed", vcount);
  endtask

  task automatic test_busy_write();
    bit got = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    kwr_en = 1'b1; kwr_addr = 4'd4; kwr_data = 8'h55;
    @(negedge clk); kwr_en = 1'b0;
    @(negedge clk);
    total++; if (kernel_o[39:32] !== 8'd1) $display("FAIL busy_write_ignored got=%h want=01", kernel_o[39:32]); else passed++;
    for (int i = 0; i < N + 20; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    total++; if (!got) $display("FAIL busy_done_timeout got=0 want=1"); else passed++;
    kwrite(4'd4, 8'h55);
    total++; if (kernel_o[39:32] !== 8'h55) $display("FAIL idle_write got=%h want=55", kernel_o[39:32]); else passed++;
    $display("busy_write: k11=%h", kernel_o[39:32]);
  endtask

  task automatic test_start_ignored();
    int dones = 0, extra_rd = 0;
    @(negedge clk); start = 1'b1;
    for (int t = 1; t <= N + 40; t++) begin
      @(negedge clk);
      if (done) dones++;
      if (t > N && mem_bus.mem_rd) extra_rd++;
      start = (t == 5) || (t == N+2);
      kwr_en = (t == N+2); kwr_addr = 4'd0; kwr_data = 8'hAA;
    end
    kwr_en = 1'b0; start = 1'b0;
    total++; if (dones != 1) $display("FAIL start_ign_dones got=%0d want=1", dones); else passed++;
    total++; if (extra_rd != 0) $display("FAIL start_ign_second_frame got=%0d want=0", extra_rd); else passed++;
    total++; if (kernel_o[7:0] !== 8'd1) $display("FAIL done_write_ignored got=%h want=01", kernel_o[7:0]); else passed++;
    $display("start_ignored: %0d done pulse(s)", dones);
  endtask

  task automatic test_midframe_reset();
    int dones = 0, rds = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (299) @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if ({pxl_o, out_valid, out_row, out_col, busy, done} !== 26'd0) $display("FAIL mid_reset_outputs got=%h want=0", {pxl_o, out_valid, out_row, out_col, busy, done}); else passed++;
    total++; if ({mem_bus.mem_rd, mem_bus.mem_addr} !== 11'd0) $display("FAIL mid_reset_mem got=%h want=0", {mem_bus.mem_rd, mem_bus.mem_addr}); else passed++;
    total++; if (kernel_o !== 72'd0) $display("FAIL mid_reset_kernel got=%h want=0", kernel_o); else passed++;
`ifdef CONV_L1_CTRL_FRAMECNT_EN
    total++; if (frame_cnt !== 16'd0) $display("FAIL mid_reset_framecnt got=%0d want=0", frame_cnt); else passed++;
`endif
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < N + 10; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (mem_bus.mem_rd) rds++;
    end
    total++; if (dones != 0 || rds != 0) $display("FAIL mid_reset_quiet got=%0d,%0d want=0,0", dones, rds); else passed++;
    $display("midframe_reset: abandoned frame, rerunning clean frame");
    test_nominal_frame();
  endtask

`ifdef CONV_L1_CTRL_FRAMECNT_EN
  task automatic test_frame_cnt();
    bit g1, g2;
    run_frame(g1);
    run_frame(g2);
    total++; if (!(g1 && g2)) $display("FAIL framecnt_timeout got=%b%b want=11", g1, g2); else passed++;
    total++; if (frame_cnt !== 16'd3) $display("FAIL framecnt got=%0d want=3", frame_cnt); else passed++;
    $display("frame_cnt: %0d", frame_cnt);
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_kernel_load();
    test_nominal_frame();
    test_datapath();
    test_busy_write();
    test_start_ignored();
    test_midframe_reset();
`ifdef CONV_L1_CTRL_FRAMECNT_EN
    test_frame_cnt();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
